// File: rtl/updown_mod_counter_sar_pkg.sv
// Shared encodings and helpers for the up/down modulo counter.
package updown_mod_counter_sar_pkg;

  // Direction as presented on up_dn.
  typedef enum logic {
    DirDown = 1'b0,
    DirUp   = 1'b1
  } dir_e;

  // Boundary behaviour as presented on sat_mode.
  typedef enum logic {
    ModeWrap = 1'b0,
    ModeSat  = 1'b1
  } mode_e;

  // Ceiling log2; clog2(1) = 0, clog2(256) = 8.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/updown_mod_counter_sar_prescaler.sv
// Prescaler: raises step on every PRESCALE-th enabled cycle.
module prescaler_sar
  import updown_mod_counter_sar_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic step
);

  // At least one bit so PRESCALE=1 still elaborates; the counter then sits at 0.
  localparam int unsigned CntWidth = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(PRESCALE - 1);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  // Step is not masked by clear; the parent gives load priority over a step.
  assign step = en & (cnt_q == CntMax);

  // Next phase: clear wins, otherwise advance and roll over while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    end
  end

  // Phase register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/updown_mod_counter_sar.sv
// Up/down modulo counter with prescaler, wrap/saturate boundary handling,
// terminal-count pulse and sticky overflow flag.
module updown_mod_counter_sar
  import updown_mod_counter_sar_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             at_bound;
  logic             boundary;
  dir_e             dir;
  mode_e            mode;

  assign dir  = dir_e'(up_dn);
  assign mode = mode_e'(sat_mode);

  // A load restarts the step phase.
  prescaler_sar #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clear(load),
    .step (step)
  );

  // Boundary value depends on the direction in force at the step.
  assign at_bound = (dir == DirUp) ? (count_q == MaxVal) : (count_q == '0);

  // Next count and flags: load > step > hold.
  always_comb begin
    count_d  = count_q;
    boundary = 1'b0;
    if (load) begin
      count_d = (load_val > MaxVal) ? MaxVal : load_val;
    end else if (step) begin
      boundary = at_bound;
      if (dir == DirUp) begin
        if (at_bound) count_d = (mode == ModeWrap) ? '0 : count_q;
        else          count_d = count_q + 1'b1;
      end else begin
        if (at_bound) count_d = (mode == ModeWrap) ? MaxVal : count_q;
        else          count_d = count_q - 1'b1;
      end
    end
    tc_d  = boundary;
    // Set beats clear on the same edge.
    ovf_d = boundary | (ovf_q & ~clr_ovf);
  end

  // Count and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q   = count_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_updown_mod_counter_sar.sv
// Directed bench for updown_mod_counter_sar: three parameterisations share
// the stimulus, each phase checks the instance it targets.
module tb_updown_mod_counter_sar;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up_dn;
  logic       sat_mode;
  logic       load;
  logic [3:0] load_val;
  logic       clr_ovf;

  logic [3:0] q0, q1, q2;
  logic       tc0, tc1, tc2;
  logic       ovf0, ovf1, ovf2;

  int n_checks;
  int n_fail;

  // Defaults: WIDTH=4, MODULUS=16, PRESCALE=1.
  updown_mod_counter_sar u_dut_def (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .up_dn   (up_dn),
    .sat_mode(sat_mode),
    .load    (load),
    .load_val(load_val),
    .clr_ovf (clr_ovf),
    .q       (q0),
    .tc      (tc0),
    .ovf     (ovf0)
  );

  updown_mod_counter_sar #(
    .WIDTH   (4),
    .MODULUS (10),
    .PRESCALE(1)
  ) u_dut_mod10 (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .up_dn   (up_dn),
    .sat_mode(sat_mode),
    .load    (load),
    .load_val(load_val),
    .clr_ovf (clr_ovf),
    .q       (q1),
    .tc      (tc1),
    .ovf     (ovf1)
  );

  updown_mod_counter_sar #(
    .WIDTH   (4),
    .MODULUS (16),
    .PRESCALE(3)
  ) u_dut_ps3 (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .up_dn   (up_dn),
    .sat_mode(sat_mode),
    .load    (load),
    .load_val(load_val),
    .clr_ovf (clr_ovf),
    .q       (q2),
    .tc      (tc2),
    .ovf     (ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse placed between clock edges.
  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    int exp_ps3 [7] = '{0, 0, 1, 1, 1, 2, 2};
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    en       = 1'b0;
    up_dn    = 1'b1;
    sat_mode = 1'b0;
    load     = 1'b0;
    load_val = 4'd0;
    clr_ovf  = 1'b0;

    // Reset state.
    #2;
    check_eq("rst q", q0, 0);
    check_eq("rst tc", tc0, 0);
    check_eq("rst ovf", ovf0, 0);
    check_eq("rst q mod10", q1, 0);
    check_eq("rst q ps3", q2, 0);

    // Default instance, up, wrap: 0..15 then 0 with tc and ovf.
    tick();
    reset = 1'b1;
    en    = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check_eq($sformatf("up q%0d", k), q0, k);
      check_eq($sformatf("up tc%0d", k), tc0, 0);
    end
    check_eq("up ovf before wrap", ovf0, 0);
    tick();
    check_eq("wrap q", q0, 0);
    check_eq("wrap tc", tc0, 1);
    check_eq("wrap ovf", ovf0, 1);
    tick();
    check_eq("after wrap q", q0, 1);
    check_eq("after wrap tc", tc0, 0);
    check_eq("after wrap ovf", ovf0, 1);

    // MODULUS=10, down, saturate from 2.
    en = 1'b0;
    pulse_reset();
    check_eq("m10 ovf after rst", ovf1, 0);
    load     = 1'b1;
    load_val = 4'd2;
    up_dn    = 1'b0;
    sat_mode = 1'b1;
    en       = 1'b1;
    tick();
    check_eq("m10 load q", q1, 2);
    check_eq("m10 load tc", tc1, 0);
    load = 1'b0;
    tick();
    check_eq("m10 dn q1", q1, 1);
    tick();
    check_eq("m10 dn q0", q1, 0);
    check_eq("m10 dn tc0", tc1, 0);
    check_eq("m10 dn ovf0", ovf1, 0);
    tick();
    check_eq("m10 sat q", q1, 0);
    check_eq("m10 sat tc", tc1, 1);
    check_eq("m10 sat ovf", ovf1, 1);
    tick();
    check_eq("m10 sat2 q", q1, 0);
    check_eq("m10 sat2 tc", tc1, 1);

    // Load clamps to MODULUS-1 and wins over a coincident step.
    load     = 1'b1;
    load_val = 4'd15;
    up_dn    = 1'b1;
    tick();
    check_eq("clamp q", q1, 9);
    check_eq("clamp tc", tc1, 0);
    load = 1'b0;
    tick();
    check_eq("sat up q", q1, 9);
    check_eq("sat up tc", tc1, 1);
    sat_mode = 1'b0;
    tick();
    check_eq("m10 wrap q", q1, 0);
    check_eq("m10 wrap tc", tc1, 1);

    // Clear coinciding with a boundary event keeps ovf set.
    load     = 1'b1;
    load_val = 4'd9;
    tick();
    check_eq("reload q", q1, 9);
    check_eq("reload tc", tc1, 0);
    check_eq("reload ovf", ovf1, 1);
    load    = 1'b0;
    clr_ovf = 1'b1;
    tick();
    check_eq("clr+evt q", q1, 0);
    check_eq("clr+evt tc", tc1, 1);
    check_eq("clr+evt ovf", ovf1, 1);
    en = 1'b0;
    tick();
    check_eq("clr ovf", ovf1, 0);
    check_eq("clr tc", tc1, 0);
    check_eq("clr q", q1, 0);
    clr_ovf = 1'b0;

    // PRESCALE=3: step every third enabled edge, phase held while en=0.
    pulse_reset();
    en       = 1'b1;
    up_dn    = 1'b1;
    sat_mode = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      check_eq($sformatf("ps3 q t%0d", k + 1), q2, exp_ps3[k]);
      check_eq($sformatf("ps3 tc t%0d", k + 1), tc2, 0);
    end
    en = 1'b0;
    tick();
    check_eq("ps3 hold1 q", q2, 2);
    tick();
    check_eq("ps3 hold2 q", q2, 2);
    en = 1'b1;
    tick();
    check_eq("ps3 resume q", q2, 2);
    tick();
    check_eq("ps3 step q", q2, 3);

    // Asynchronous reset at q=7 with ovf set.
    en = 1'b0;
    pulse_reset();
    load     = 1'b1;
    load_val = 4'd15;
    en       = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check_eq("pre-async wrap ovf", ovf0, 1);
    for (int k = 0; k < 7; k++) tick();
    check_eq("pre-async q", q0, 7);
    check_eq("pre-async ovf", ovf0, 1);
    en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_eq("async q", q0, 0);
    check_eq("async tc", tc0, 0);
    check_eq("async ovf", ovf0, 0);
    tick();
    reset = 1'b1;
    en    = 1'b1;
    tick();
    check_eq("post-rst first step q", q0, 1);
    check_eq("post-rst tc", tc0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
